// File: rtl/prog_seq.sv
// Program run sequencer: holds the program counter in init for a fixed
// number of cycles, lets it run until halt or a cycle limit, then reports.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; PC held in init; last results visible
// INIT    | PC held in init for INIT_CYCLES cycles; halt ignored
// RUN     | PC free-running; counting cycles until halt or limit
// DONE    | one-cycle completion pulse; results captured
module prog_seq #(
    parameter int unsigned INIT_CYCLES = 2,
    parameter logic [15:0] MAX_CYCLES  = 16'd4000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic        halt,
    input  logic [9:0]  PC,
    output logic        init,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] cycle_count,
    output logic [9:0]  final_pc
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Down-counter reaches zero on the last INIT cycle.
    localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  init_cnt_q, init_cnt_d;
    logic [15:0] cycle_cnt_q, cycle_cnt_d;
    logic [9:0]  final_pc_q, final_pc_d;
    logic        timeout_q, timeout_d;
    logic [15:0] cycle_inc;

    assign cycle_inc = (cycle_cnt_q < MAX_CYCLES) ? cycle_cnt_q + 16'd1 : cycle_cnt_q;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        final_pc_d  = final_pc_q;
        timeout_d   = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_INIT;
                    init_cnt_d  = INIT_LOAD;
                    cycle_cnt_d = 16'd0;
                    final_pc_d  = 10'd0;
                    timeout_d   = 1'b0;
                end
            end
            ST_INIT: begin
                if (init_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q - 4'd1;
                end
            end
            ST_RUN: begin
                // Halt takes priority over the limit on the same edge.
                if (halt) begin
                    state_d    = ST_DONE;
                    final_pc_d = PC;
                    timeout_d  = 1'b0;
                end else begin
                    cycle_cnt_d = cycle_inc;
                    if (cycle_inc == MAX_CYCLES) begin
                        state_d    = ST_DONE;
                        final_pc_d = PC;
                        timeout_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            init_cnt_q  <= 4'd0;
            cycle_cnt_q <= 16'd0;
            final_pc_q  <= 10'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            final_pc_q  <= final_pc_d;
            timeout_q   <= timeout_d;
        end
    end

    assign init        = (state_q == ST_IDLE) || (state_q == ST_INIT);
    assign busy        = (state_q == ST_INIT) || (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign timeout     = timeout_q;
    assign cycle_count = cycle_cnt_q;
    assign final_pc    = final_pc_q;

endmodule

// File: doc/prog_seq.md
PROG_SEQ -- requirements
Module: prog_seq

Interface
REQ-001 Parameter INIT_CYCLES, default 2, number of cycles init is held after a start request (legal range 1..15).
REQ-002 Parameter MAX_CYCLES, default 16'd4000, run-cycle limit before timeout (legal range 1..65535).
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  run request, sampled only in IDLE.
REQ-006 halt  input  1  halt flag from the program counter.
REQ-007 PC  input  10  current program counter value.
REQ-008 init  output  1  program counter initialise, active-high.
REQ-009 busy  output  1  high in INIT and RUN.
REQ-010 done  output  1  one-cycle pulse at run completion.
REQ-011 timeout  output  1  completion status: run ended on MAX_CYCLES, not halt.
REQ-012 cycle_count  output  16  run cycles counted for the last or current run.
REQ-013 final_pc  output  10  PC captured at run completion.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, INIT, RUN, DONE.
REQ-015 IDLE: start=1 -> INIT; otherwise stay.
REQ-016 INIT: held for exactly INIT_CYCLES cycles, then -> RUN; halt ignored.
REQ-017 RUN: halt=1 sampled -> DONE; else count reaching MAX_CYCLES -> DONE.
REQ-018 DONE: lasts one cycle, unconditionally -> IDLE.
REQ-019 init SHALL be decoded from state: 1 in IDLE and INIT, 0 in RUN and DONE.
REQ-020 busy SHALL be 1 in INIT and RUN only; done SHALL be 1 in DONE only.
REQ-021 start in INIT, RUN or DONE SHALL be ignored, with no queuing.
REQ-022 On the IDLE->INIT edge, cycle_count, timeout and final_pc SHALL clear to 0.
REQ-023 In RUN, every edge sampling halt=0 SHALL increment cycle_count by 1.
REQ-024 cycle_count SHALL saturate at MAX_CYCLES.
REQ-025 When halt=1 is sampled in RUN, cycle_count SHALL not increment.
REQ-026 On RUN->DONE, final_pc SHALL capture the PC value sampled on that edge.
REQ-027 On RUN->DONE, timeout SHALL be set to 1 only if the exit was by count limit.
REQ-028 If halt=1 on the edge where the count reaches MAX_CYCLES, halt wins and timeout=0.
REQ-029 cycle_count, final_pc and timeout SHALL hold their values through DONE and IDLE until the next start.
REQ-030 INIT length SHALL use an internal 4-bit counter loaded on IDLE->INIT.

Reset
REQ-031 RST_N=0 SHALL, asynchronously and in any state, force: state IDLE, init=1, busy=0, done=0, timeout=0, cycle_count=0, final_pc=0, INIT counter=0.
REQ-032 After RST_N deasserts, operation SHALL resume from IDLE on the next rising CLK edge.
REQ-033 RST_N asserted mid-RUN SHALL abort the run with no done pulse.

Verification
REQ-034 Reset then idle: RST_N low 3 cycles, start=0 -> init=1, busy=0, done=0, all counters 0.
REQ-035 Normal halt run, defaults: pulse start; after exactly 2 init cycles, hold halt=0 for 10 RUN edges, then halt=1, PC=10'd64 -> done pulses once, cycle_count=10, final_pc=64, timeout=0, init=1 next cycle.
REQ-036 Timeout run, MAX_CYCLES=20: start, halt held 0 -> DONE after 20 RUN edges, cycle_count=20, timeout=1, final_pc=PC at that edge.
REQ-037 Coincident limit, MAX_CYCLES=20: halt=1 on the 20th RUN edge -> timeout=0, cycle_count=19.
REQ-038 Stale halt and ignored start: halt=1 throughout INIT, and start pulsed during RUN -> no early exit from INIT, no restart, exactly one done per run.
REQ-039 Mid-run reset: RST_N=0 asynchronously at RUN cycle 5 -> immediate IDLE, outputs at reset values, done never asserted.
